dm_arbiter: RTL and testbench

Shares the single-port data memory between the processor core and one external requester (DMA / IO port). The core's dm_CEn/OEn/WEn strobes and address pass through unchanged when the external side is idle. The external requester gets bounded-latency bursts, during which the core is stalled through its hold input. The block sits between the control/datapath outputs and the data RAM.

---
 rtl/dm_arbiter.sv | 133 +++++++++++++
 tb/tb_dm_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the core and one
// external requester. The core passes straight through while the external side
// is idle. The external side gets bounded bursts, and the core is held through
// hold_o while a burst runs.
module dm_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRRAM_WIDTH = 10,
    parameter int WAIT_LIMIT    = 8,
    parameter int BURST_MAX     = 4,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                     clock_i,
    input  logic                     nreset_i,
    input  logic [ADDRRAM_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]    cpu_data_i,
    input  logic                     cpu_CEn_i,
    input  logic                     cpu_OEn_i,
    input  logic                     cpu_WEn_i,
    output logic                     hold_o,
    input  logic                     ext_req_i,
    input  logic                     ext_we_i,
    input  logic [ADDRRAM_WIDTH-1:0] ext_addr_i,
    input  logic [DATA_WIDTH-1:0]    ext_data_i,
    output logic                     ext_gnt_o,
    output logic                     ext_rvalid_o,
    output logic [DATA_WIDTH-1:0]    ext_rdata_o,
    output logic [ADDRRAM_WIDTH-1:0] dm_addr_o,
    output logic [DATA_WIDTH-1:0]    dm_data_o,
    output logic                     dm_CEn_o,
    output logic                     dm_OEn_o,
    output logic                     dm_WEn_o,
    input  logic [DATA_WIDTH-1:0]    dm_data_i
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_EXT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] WAIT_MAX   = CNT_WIDTH'(WAIT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(BURST_MAX - 1);

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_nxt;
    logic [CNT_WIDTH-1:0]  burst_cnt, burst_cnt_nxt;
    logic                  ext_read;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rdata_p1;

    // Next-state, counters and memory-port steering for the current owner.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        burst_cnt_nxt = burst_cnt;
        ext_read      = 1'b0;
        dm_addr_o     = cpu_addr_i;
        dm_data_o     = cpu_data_i;
        dm_CEn_o      = cpu_CEn_i;
        dm_OEn_o      = cpu_OEn_i;
        dm_WEn_o      = cpu_WEn_i;
        case (state)
            S_CPU: begin
                if (ext_req_i) begin
                    // Grant at once when the core is idle; otherwise only once
                    // the external side has waited its full allowance.
                    if (cpu_CEn_i || (wait_cnt == WAIT_MAX)) begin
                        state_nxt     = S_EXT;
                        wait_cnt_nxt  = '0;
                        burst_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    wait_cnt_nxt = '0;
                end
            end
            S_EXT: begin
                dm_addr_o    = ext_addr_i;
                dm_data_o    = ext_data_i;
                dm_CEn_o     = 1'b1;
                dm_OEn_o     = 1'b1;
                dm_WEn_o     = 1'b1;
                wait_cnt_nxt = '0;
                if (ext_req_i) begin
                    dm_CEn_o      = 1'b0;
                    dm_OEn_o      = ext_we_i;
                    dm_WEn_o      = ~ext_we_i;
                    ext_read      = ~ext_we_i;
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = S_CPU;
                    end
                end else begin
                    state_nxt = S_CPU;
                end
            end
            default: state_nxt = S_CPU;
        endcase
    end

    // State and counter registers; reset drops any burst in progress.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state     <= S_CPU;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Read return stage: flag one cycle after an external read strobe and keep
    // the last returned word for the external side between reads.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= ext_read;
            if (vld_p1) begin
                rdata_p1 <= dm_data_i;
            end
        end
    end

    assign hold_o       = (state == S_EXT);
    assign ext_gnt_o    = (state == S_EXT);
    assign ext_rvalid_o = vld_p1;
    assign ext_rdata_o  = vld_p1 ? dm_data_i : rdata_p1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed phases followed by random traffic, with a
// transaction-level ownership model and a read-return scoreboard.
module tb_dm_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int WAIT_LIMIT = 8;
    localparam int BURST_MAX  = 4;

    logic          clk;
    logic          nreset_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_data_i;
    logic          cpu_CEn_i, cpu_OEn_i, cpu_WEn_i;
    logic          hold_o;
    logic          ext_req_i, ext_we_i;
    logic [AW-1:0] ext_addr_i;
    logic [DW-1:0] ext_data_i;
    logic          ext_gnt_o, ext_rvalid_o;
    logic [DW-1:0] ext_rdata_o;
    logic [AW-1:0] dm_addr_o;
    logic [DW-1:0] dm_data_o;
    logic          dm_CEn_o, dm_OEn_o, dm_WEn_o;
    logic [DW-1:0] dm_data_i;

    dm_arbiter #(
        .DATA_WIDTH(DW), .ADDRRAM_WIDTH(AW), .WAIT_LIMIT(WAIT_LIMIT),
        .BURST_MAX(BURST_MAX), .CNT_WIDTH(4)
    ) dut (
        .clock_i(clk), .nreset_i(nreset_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_CEn_i(cpu_CEn_i), .cpu_OEn_i(cpu_OEn_i), .cpu_WEn_i(cpu_WEn_i),
        .hold_o(hold_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i),
        .ext_addr_i(ext_addr_i), .ext_data_i(ext_data_i),
        .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
        .dm_addr_o(dm_addr_o), .dm_data_o(dm_data_o),
        .dm_CEn_o(dm_CEn_o), .dm_OEn_o(dm_OEn_o), .dm_WEn_o(dm_WEn_o),
        .dm_data_i(dm_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM driven by the arbiter's memory port.
    logic [DW-1:0] ram [0:1023] = '{default: 16'h0000};
    logic [DW-1:0] ram_q = 16'h0000;
    always @(posedge clk) begin
        if (!dm_CEn_o) begin
            if (!dm_WEn_o)      ram[dm_addr_o] <= dm_data_o;
            else if (!dm_OEn_o) ram_q <= ram[dm_addr_o];
        end
    end
    assign dm_data_i = ram_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, how long the external side has
    // waited, how many accesses the current burst has used, and memory contents.
    bit            m_ext = 0;
    int            m_wait = 0;
    int            m_beats = 0;
    logic [DW-1:0] gold [0:1023] = '{default: 16'h0000};
    logic [DW-1:0] exp_q [$];

    // Staged stimulus for the next cycle.
    logic          s_rn = 0;
    logic [AW-1:0] s_ca = '0, s_ea = '0;
    logic [DW-1:0] s_cd = '0, s_ed = '0;
    logic          s_cce = 1, s_coe = 1, s_cwe = 1, s_er = 0, s_ewe = 0;
    logic          obs_gnt;

    task automatic tick();
        logic          e_ce, e_oe, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        @(negedge clk);
        nreset_i   = s_rn;
        cpu_addr_i = s_ca; cpu_data_i = s_cd;
        cpu_CEn_i  = s_cce; cpu_OEn_i = s_coe; cpu_WEn_i = s_cwe;
        ext_req_i  = s_er; ext_we_i = s_ewe; ext_addr_i = s_ea; ext_data_i = s_ed;
        #1;
        if (!s_rn) begin
            m_ext = 0; m_wait = 0; m_beats = 0;
            exp_q.delete();
        end
        if (m_ext) begin
            e_addr = s_ea; e_data = s_ed;
            if (s_er) {e_ce, e_oe, e_we} = {1'b0, s_ewe, ~s_ewe};
            else      {e_ce, e_oe, e_we} = 3'b111;
        end else begin
            e_addr = s_ca; e_data = s_cd;
            {e_ce, e_oe, e_we} = {s_cce, s_coe, s_cwe};
        end
        obs_gnt = ext_gnt_o;
        chk("hold", hold_o, m_ext);
        chk("gnt", ext_gnt_o, m_ext);
        chk("dm_strobes", {dm_CEn_o, dm_OEn_o, dm_WEn_o}, {e_ce, e_oe, e_we});
        if (!e_ce) chk("dm_addr", dm_addr_o, e_addr);
        if (!e_ce && !e_we) chk("dm_data", dm_data_o, e_data);
        if (!s_rn) begin
            chk("rst_rvalid", ext_rvalid_o, 1'b0);
            chk("rst_rdata", ext_rdata_o, 16'h0000);
        end
        @(posedge clk);
        if (!e_ce && !e_we) gold[e_addr] = e_data;
        if (s_rn) begin
            if (!m_ext) begin
                if (s_er) begin
                    if (s_cce || m_wait == WAIT_LIMIT) begin
                        m_ext = 1; m_wait = 0; m_beats = 0;
                    end else begin
                        m_wait = (m_wait < WAIT_LIMIT) ? m_wait + 1 : WAIT_LIMIT;
                    end
                end else begin
                    m_wait = 0;
                end
            end else if (s_er) begin
                if (!s_ewe) exp_q.push_back(gold[s_ea]);
                m_beats++;
                if (m_beats == BURST_MAX) m_ext = 0;
            end else begin
                m_ext = 0;
            end
        end
    endtask

    // Read-return monitor: every external read must come back one cycle later.
    initial begin
        logic [DW-1:0] d;
        forever begin
            @(posedge clk);
            #2;
            chk("rvalid", ext_rvalid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                d = exp_q.pop_front();
                if (ext_rvalid_o) chk("ext_rdata", ext_rdata_o, d);
            end
        end
    end

    task automatic cpu_idle();
        s_cce = 1; s_coe = 1; s_cwe = 1;
    endtask

    int issued, n_at, cur_run;
    int runs [$];
    bit granted;

    initial begin
        nreset_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        cpu_CEn_i = 1; cpu_OEn_i = 1; cpu_WEn_i = 1;
        ext_req_i = 0; ext_we_i = 0; ext_addr_i = '0; ext_data_i = '0;

        // Reset with random inputs, then with the core idle.
        s_rn = 0;
        for (int i = 0; i < 4; i++) begin
            s_ca = AW'($urandom_range(0, 15)); s_cd = DW'($urandom);
            s_cce = 1'($urandom); s_coe = 1'($urandom); s_cwe = 1'($urandom);
            s_er = 1'($urandom); s_ewe = 1'($urandom);
            s_ea = AW'($urandom); s_ed = DW'($urandom);
            tick();
        end
        cpu_idle(); s_er = 0;
        tick();
        s_rn = 1;
        tick(); tick();

        // Core pass-through: read 0x05, write 0x1234 to 0x07.
        s_ca = 10'h005; s_cce = 0; s_coe = 0; s_cwe = 1; tick();
        s_ca = 10'h007; s_cd = 16'h1234; s_cce = 0; s_coe = 1; s_cwe = 0; tick();
        // Preload 0x10/0x11 through the core.
        s_ca = 10'h010; s_cd = 16'hAAAA; tick();
        s_ca = 10'h011; s_cd = 16'hBBBB; tick();
        cpu_idle(); tick();

        // Idle grant with two external reads.
        issued = 0;
        for (int i = 0; i < 10 && issued < 2; i++) begin
            s_er = 1; s_ewe = 0; s_ea = AW'(10'h010 + issued);
            granted = m_ext;
            tick();
            if (granted) issued++;
        end
        s_er = 0; tick(); tick(); tick();

        // Forced hold: core busy every cycle, external side must wait.
        n_at = 20;
        for (int i = 0; i < 20; i++) begin
            s_cce = 0; s_coe = 0; s_cwe = 1; s_ca = AW'($urandom_range(0, 15));
            s_er = 1; s_ewe = 0; s_ea = 10'h020;
            tick();
            if (obs_gnt) begin
                n_at = i;
                break;
            end
        end
        chk("grant_latency", n_at, WAIT_LIMIT + 1);
        s_er = 0; tick();
        cpu_idle(); tick(); tick();

        // Burst cap: ten writes with the request held high.
        issued = 0; cur_run = 0;
        for (int i = 0; i < 60; i++) begin
            s_er = (issued < 10); s_ewe = 1;
            s_ea = AW'(10'h100 + issued); s_ed = DW'(16'hC000 + issued);
            granted = m_ext;
            tick();
            if (granted && s_er) issued++;
            if (obs_gnt) cur_run++;
            else if (cur_run != 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
            if (!s_er && !obs_gnt && i > 2) break;
        end
        chk("burst_count", runs.size() >= 2, 1'b1);
        if (runs.size() >= 2) begin
            chk("burst0_len", runs[0], BURST_MAX);
            chk("burst1_len", runs[1], BURST_MAX);
        end
        tick();
        for (int i = 0; i < 10; i++) chk("burst_ram", ram[10'h100 + i], 16'hC000 + i);

        // Reset on the second beat of a read burst.
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            s_er = 1; s_ewe = 0; s_ea = AW'(10'h010 + issued);
            granted = m_ext;
            if (granted && issued == 1) begin
                s_rn = 0; s_cce = 0; s_coe = 0; s_cwe = 1; s_ca = 10'h007;
                tick();
                break;
            end
            tick();
            if (granted) issued++;
        end
        s_er = 0; cpu_idle(); tick();
        s_rn = 1; tick();
        // After release the wait count restarts from zero.
        for (int i = 0; i < 12; i++) begin
            s_cce = 0; s_coe = 0; s_cwe = 1; s_ca = AW'($urandom_range(0, 15));
            s_er = 1; s_ewe = 0; s_ea = 10'h011;
            tick();
        end
        s_er = 0; cpu_idle(); tick(); tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            s_rn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) s_er = ~s_er;
            s_ewe = 1'($urandom);
            s_ea = AW'($urandom_range(0, 15)); s_ed = DW'($urandom);
            s_cce = 1'($urandom); s_coe = 1'($urandom); s_cwe = 1'($urandom);
            s_ca = AW'($urandom_range(0, 15)); s_cd = DW'($urandom);
            tick();
        end
        s_rn = 1; s_er = 0; cpu_idle();
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
